// File: rtl/mem_access_unit_if.sv
// Request/response bus between the MEM stage and the load/store unit,
// plus the word-wide dmem port the unit drives.
interface mem_access_unit_if;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req, op, addr, wdata, mem_rdata,
        output busy, done, rdata, err, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req, op, addr, wdata, mem_rdata,
        input  busy, done, rdata, err, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit for a word-only dmem: sub-word stores via read-modify-write,
// sub-word loads extracted and extended. LSU_BOUNDS_CHECK_EN adds a dmem range check.
module mem_access_unit #(
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int DMEM_WORDS = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_unit_if.slave bus
);
    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

`ifdef LSU_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, RMW_WR, DONE} state_t;

    state_t      state, state_nx;
    logic [2:0]  op_q;
    logic [31:0] addr_q, wdata_q, word_q, rdata_q;
    logic        err_q;

    logic        misaligned, out_of_range, reject;
    logic [4:0]  byte_sh, half_sh;
    logic [7:0]  rd_b;
    logic [15:0] rd_h;
    logic [31:0] load_val, lane_mask, lane_ins, store_val;
    logic        busy, done, mem_read, mem_write;
    logic [31:0] mem_wdata;

    // Rejected accesses skip the memory entirely and report through DONE.
    always_comb begin
        misaligned = 1'b0;
        case (bus.op)
            OP_LW, OP_SW:         misaligned = (bus.addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: misaligned = bus.addr[0];
            default:              misaligned = 1'b0;
        endcase
        out_of_range = ({2'b00, bus.addr[31:2]} >= 32'(DMEM_WORDS));
        reject       = misaligned | (BOUNDS_EN & out_of_range);
    end

    // Bit position of the addressed lane; big-endian puts offset 0 in the top byte.
    always_comb begin
        byte_sh = BIG_ENDIAN ? {~addr_q[1:0], 3'b000} : {addr_q[1:0], 3'b000};
        half_sh = BIG_ENDIAN ? {~addr_q[1], 4'b0000}  : {addr_q[1], 4'b0000};
    end

    always_comb begin
        rd_b = 8'(bus.mem_rdata >> byte_sh);
        rd_h = 16'(bus.mem_rdata >> half_sh);
        case (op_q)
            OP_LH:   load_val = {{16{rd_h[15]}}, rd_h};
            OP_LHU:  load_val = {16'h0000, rd_h};
            OP_LB:   load_val = {{24{rd_b[7]}}, rd_b};
            OP_LBU:  load_val = {24'h000000, rd_b};
            default: load_val = bus.mem_rdata;
        endcase
    end

    always_comb begin
        if (op_q == OP_SH) begin
            lane_mask = 32'h0000_FFFF << half_sh;
            lane_ins  = {16'h0000, wdata_q[15:0]} << half_sh;
        end else begin
            lane_mask = 32'h0000_00FF << byte_sh;
            lane_ins  = {24'h000000, wdata_q[7:0]} << byte_sh;
        end
        store_val = (word_q & ~lane_mask) | lane_ins;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = 32'h0;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (reject)                                  state_nx = DONE;
                    else if (bus.op == OP_SH || bus.op == OP_SB) state_nx = RMW_RD;
                    else                                         state_nx = ACCESS;
                end
            end
            ACCESS: begin
                if (op_q == OP_SW) begin
                    mem_write = 1'b1;
                    mem_wdata = wdata_q;
                end else begin
                    mem_read  = 1'b1;
                end
                state_nx = DONE;
            end
            RMW_RD: begin
                mem_read = 1'b1;
                state_nx = RMW_WR;
            end
            RMW_WR: begin
                mem_write = 1'b1;
                mem_wdata = store_val;
                state_nx  = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q    <= OP_LW;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            word_q  <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        op_q    <= bus.op;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        err_q   <= reject;
                    end
                end
                ACCESS:  if (op_q != OP_SW) rdata_q <= load_val;
                RMW_RD:  word_q <= bus.mem_rdata;
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q & done;
    assign bus.mem_read  = mem_read;
    assign bus.mem_write = mem_write;
    assign bus.mem_addr  = {addr_q[31:2], 2'b00};
    assign bus.mem_wdata = mem_wdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboarded random bench for mem_access_unit: byte-addressed reference memory,
// a word-wide dmem model on the bus, and a monitor that checks each done pulse.
module tb_mem_access_unit;
    localparam bit BIG   = 1'b1;
    localparam int WORDS = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if bus();

    mem_access_unit #(.BIG_ENDIAN(BIG), .DMEM_WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Word-wide dmem model with a preload port used while reset is held.
    logic [31:0] dmem [WORDS];
    logic        init_we = 1'b0;
    logic [5:0]  init_idx = '0;
    logic [31:0] init_data = '0;
    always @(posedge clk) begin
        if (init_we)            dmem[init_idx] <= init_data;
        else if (bus.mem_write) dmem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = dmem[bus.mem_addr[7:2]];

    // Reference memory as plain bytes; dmem aliases addresses through addr[7:0].
    logic [7:0] rb [256];

    function automatic logic [31:0] word_of(input logic [7:0] b);
        if (BIG) return {rb[b], rb[b+1], rb[b+2], rb[b+3]};
        else     return {rb[b+3], rb[b+2], rb[b+1], rb[b]};
    endfunction

    typedef struct {
        bit          is_load;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        int          t0;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w,
                         output exp_t e);
        logic       mis, oob;
        logic [7:0] p, b, hi, lo;
        mis = ((op == 3'd0 || op == 3'd5) && a[1:0] != 2'b00) ||
              ((op == 3'd1 || op == 3'd2 || op == 3'd6) && a[0]);
        oob = 1'b0;
`ifdef LSU_BOUNDS_CHECK_EN
        oob = (a[31:2] >= 30'(WORDS));
`endif
        e.is_load = (op < 3'd5);
        e.err     = mis | oob;
        e.rdata   = 32'h0;
        e.t0      = 0;
        if (e.err) begin
            e.lat = 1; e.nrd = 0; e.nwr = 0;
        end else begin
            p  = a[7:0];
            b  = {p[7:2], 2'b00};
            hi = BIG ? rb[p] : rb[p+1];
            lo = BIG ? rb[p+1] : rb[p];
            case (op)
                3'd0: e.rdata = word_of(b);
                3'd1: e.rdata = {{16{hi[7]}}, hi, lo};
                3'd2: e.rdata = {16'h0, hi, lo};
                3'd3: e.rdata = {{24{rb[p][7]}}, rb[p]};
                3'd4: e.rdata = {24'h0, rb[p]};
                3'd5: begin
                    if (BIG) begin rb[b] = w[31:24]; rb[b+1] = w[23:16]; rb[b+2] = w[15:8]; rb[b+3] = w[7:0]; end
                    else     begin rb[b] = w[7:0];   rb[b+1] = w[15:8];  rb[b+2] = w[23:16]; rb[b+3] = w[31:24]; end
                end
                3'd6: begin
                    if (BIG) begin rb[p] = w[15:8]; rb[p+1] = w[7:0]; end
                    else     begin rb[p] = w[7:0];  rb[p+1] = w[15:8]; end
                end
                default: rb[p] = w[7:0];
            endcase
            e.lat = (op >= 3'd6) ? 3 : 2;
            e.nrd = (op == 3'd5) ? 0 : 1;
            e.nwr = (op >= 3'd5) ? 1 : 0;
        end
    endtask

    // Monitor: strobe counts per transaction, idle write data, and done-time checks.
    always @(negedge clk) begin
        if (!mon_en) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            rd_cnt += int'(bus.mem_read);
            wr_cnt += int'(bus.mem_write);
            if (!bus.mem_write) chk("mem_wdata_idle", bus.mem_wdata, 32'h0);
            if (bus.done) begin
                compared++;
                if (sbq.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_done: got done=1 expected no transaction");
                end else begin
                    mon_e = sbq.pop_front();
                    chk("err", 32'(bus.err), 32'(mon_e.err));
                    chk("latency", 32'(cyc - mon_e.t0 + 1), 32'(mon_e.lat));
                    chk("mem_read_pulses", 32'(rd_cnt), 32'(mon_e.nrd));
                    chk("mem_write_pulses", 32'(wr_cnt), 32'(mon_e.nwr));
                    if (mon_e.is_load && !mon_e.err) chk("rdata", bus.rdata, mon_e.rdata);
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    // Called at a negedge with the DUT idle; junk requests are driven while busy.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w);
        exp_t e;
        bit   got;
        model(op, a, w, e);
        bus.req = 1'b1; bus.op = op; bus.addr = a; bus.wdata = w;
        @(posedge clk);
        #1;
        e.t0 = cyc;
        sbq.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got       = bus.done;
            bus.req   = 1'($urandom_range(0, 1));
            bus.op    = 3'($urandom);
            bus.addr  = $urandom;
            bus.wdata = $urandom;
        end
        compared++;
        if (!got) begin
            mismatched++;
            $display("FAIL timeout: got no done within 8 cycles expected done (op=%0d addr=%h)", op, a);
        end
        @(negedge clk);
        bus.req = 1'b0;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        int          r;
        bus.req = 1'b0; bus.op = 3'd0; bus.addr = 32'h0; bus.wdata = 32'h0;
        for (int i = 0; i < 256; i++) rb[i] = 8'($urandom);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < WORDS; i++) begin
            init_we = 1'b1; init_idx = 6'(i); init_data = word_of(8'(i * 4));
            @(negedge clk);
        end
        init_we = 1'b0;

        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_err", 32'(bus.err), 32'h0);
        chk("rst_mem_read", 32'(bus.mem_read), 32'h0);
        chk("rst_mem_write", 32'(bus.mem_write), 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);

        // Release reset with an SB already requested, then abort it mid read-modify-write.
        rst_n = 1'b1;
        bus.req = 1'b1; bus.op = 3'd7; bus.addr = 32'h12; bus.wdata = 32'h55;
        @(negedge clk);
        chk("sb_started_busy", 32'(bus.busy), 32'h1);
        chk("sb_started_read", 32'(bus.mem_read), 32'h1);
        rst_n = 1'b0; bus.req = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 32'h0);
        chk("abort_mem_write", 32'(bus.mem_write), 32'h0);
        chk("abort_mem_read", 32'(bus.mem_read), 32'h0);
        chk("abort_done", 32'(bus.done), 32'h0);
        chk("abort_word", dmem[4], word_of(8'h10));

        mon_en = 1'b1;
        rst_n  = 1'b1;
        issue(3'd5, 32'h10, 32'hDEAD_BEEF);
        issue(3'd0, 32'h10, 32'h0);
        issue(3'd5, 32'h10, 32'h1122_3344);
        issue(3'd7, 32'h12, 32'h0000_00AA);
        issue(3'd0, 32'h10, 32'h0);
        issue(3'd5, 32'h10, 32'h80FF_7F01);
        issue(3'd3, 32'h10, 32'h0);
        issue(3'd4, 32'h10, 32'h0);
        issue(3'd1, 32'h12, 32'h0);
        issue(3'd2, 32'h10, 32'h0);
        issue(3'd0, 32'h13, 32'h0);
        issue(3'd6, 32'h11, 32'h1234);
        issue(3'd5, 32'h100, 32'hCAFE_F00D);
        issue(3'd0, 32'h0, 32'h0);

        for (int n = 0; n < 400; n++) begin
            op = 3'($urandom_range(0, 7));
            r  = $urandom_range(0, 7);
            a  = (r == 0) ? $urandom : 32'($urandom_range(0, 255));
            if (r >= 1 && r < 5) begin
                if (op == 3'd0 || op == 3'd5)                    a[1:0] = 2'b00;
                else if (op == 3'd1 || op == 3'd2 || op == 3'd6) a[0]   = 1'b0;
            end
            issue(op, a, $urandom);
        end

        repeat (2) @(negedge clk);
        compared++;
        if (sbq.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
